pipeline_control_unit: RTL and testbench
========================================

Name: pipeline_control_unit

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Merges three request sources into one consistent set of per-register enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB:
  - load-use hazard from the hazard detection unit;
  - branch-taken from decode, since branches resolve in ID;
  - data-memory wait from the MEM stage.
- Runs a watchdog that halts the core on a stuck memory access.

Parameters:
- MEM_TIMEOUT, 16: max consecutive data-memory wait cycles before halt; 1..255.
- CNT_W, 8: width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_use_hazard  in  1  ID instruction depends on a load in EX.
- branch_taken  in  1  ID branch resolved taken this cycle.
- dmem_req  in  1  MEM stage holds a load or store (mem_read|mem_write).
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_enable  out  1  PC register load enable.
- if_id_enable  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads a NOP bubble.
- id_ex_enable  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX loads zeroed control (bubble).
- ex_mem_enable  out  1  EX/MEM load enable.
- mem_wb_flush  out  1  MEM/WB loads a bubble (reg_write=0).
- halted  out  1  core halted by timeout; sticky.
- stall_cycles  out  32  performance counter (see Optional Feature).

Behaviour:
- All outputs are combinational from the state register and current inputs; stalls take effect in the same cycle the condition is present.
- freeze = dmem_req & ~dmem_ready.
- While reset=0:
  - state=RUN, wait_cnt=0, halted=0, stall_cycles=0.
  - All enables=0, all flushes=0.
- States: RUN, DMEM_WAIT, HALT.
- RUN / DMEM_WAIT, priority order:
  1. freeze:
     - pc/if_id/id_ex/ex_mem enables=0; if_id_flush=0; id_ex_flush=0.
     - mem_wb_flush=1, so WB does not repeat a write.
     - branch_taken and load_use_hazard are ignored.
  2. load_use_hazard:
     - pc_enable=0, if_id_enable=0, id_ex_flush=1, id_ex_enable=1, ex_mem_enable=1.
     - branch_taken is ignored, because branch operands are not ready.
  3. branch_taken:
     - all enables=1, if_id_flush=1 (squash the fetched instruction).
     - pc_enable=1 loads the branch target.
  4. otherwise: all enables=1, all flushes=0.
- Transitions:
  - RUN, freeze=1: go to DMEM_WAIT, wait_cnt<=1.
  - DMEM_WAIT, freeze=1 and wait_cnt==MEM_TIMEOUT-1: go to HALT, halted<=1.
  - DMEM_WAIT, freeze=1 otherwise: wait_cnt<=wait_cnt+1.
  - DMEM_WAIT, freeze=0: the ready cycle advances normally per the priorities above; go to RUN, wait_cnt<=0.
- The access therefore completes in the cycle dmem_ready=1. The next cycle sees the following MEM instruction, so the same request cannot re-trigger a wait.
- HALT:
  - All enables=0, all flushes=0, halted=1; all inputs are ignored.
  - Exit only by reset.
- A wait of exactly MEM_TIMEOUT-1 frozen cycles followed by ready does not halt. The MEM_TIMEOUT-th consecutive frozen cycle enters HALT.
- reset asserted mid-wait or in HALT: immediate return to RUN with counters cleared, asynchronously.
- wait_cnt saturates and never wraps.

Optional Feature:
- Macro: PIPE_STALL_PERF_EN.
- Defined: stall_cycles increments by 1 each clock in which state≠HALT and pc_enable=0 (freeze or load-use). It wraps modulo 2^32 and clears on reset.
- Undefined: stall_cycles is constant 0 and no counter register is built.

Test Plan:
- Reset release, all inputs 0: enables=1 and flushes=0 from the first cycle after reset=1; halted=0.
- load_use_hazard=1 for 1 cycle with branch_taken=1: that cycle pc_enable=0, if_id_enable=0, id_ex_flush=1, if_id_flush=0. The next cycle all enables=1.
- branch_taken=1 alone: if_id_flush=1 and pc_enable=1 for exactly that cycle.
- dmem_req=1 with dmem_ready=0 for 3 cycles, then ready=1:
  - 3 cycles of upstream enables=0 and mem_wb_flush=1;
  - the 4th cycle all enables=1;
  - state returns to RUN;
  - stall_cycles=3 with PIPE_STALL_PERF_EN.
- MEM_TIMEOUT=4, dmem_ready held 0: halted=1 after the 4th frozen cycle, all enables=0 thereafter. Asserting dmem_ready=1 has no effect. reset=0 clears halted.
- freeze together with load_use_hazard=1 and branch_taken=1: freeze outputs only (id_ex_flush=0, if_id_flush=0, mem_wb_flush=1).

Source files
------------

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline with a data-memory watchdog.
// Optional stall-cycle performance counter enabled by PIPE_STALL_PERF_EN.
module pipeline_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_use_hazard,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_enable,
  output logic        if_id_enable,
  output logic        if_id_flush,
  output logic        id_ex_enable,
  output logic        id_ex_flush,
  output logic        ex_mem_enable,
  output logic        mem_wb_flush,
  output logic        halted,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {StRun, StDmemWait, StHalt} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             freeze;

  logic pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, mem_wb_fl;

  assign freeze = dmem_req & ~dmem_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pc_en      = 1'b0;
    if_id_en   = 1'b0;
    if_id_fl   = 1'b0;
    id_ex_en   = 1'b0;
    id_ex_fl   = 1'b0;
    ex_mem_en  = 1'b0;
    mem_wb_fl  = 1'b0;
    unique case (state_q)
      StRun, StDmemWait: begin
        if (freeze) begin
          // Bubble into WB so the frozen MEM instruction does not write twice.
          mem_wb_fl = 1'b1;
          if (state_q == StRun) begin
            if (MEM_TIMEOUT == 1) begin
              state_d = StHalt;
            end else begin
              state_d    = StDmemWait;
              wait_cnt_d = CNT_W'(1);
            end
          end else if (wait_cnt_q == CntLast) begin
            state_d = StHalt;
          end else if (wait_cnt_q != CntMax) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d    = StRun;
          wait_cnt_d = '0;
          id_ex_en   = 1'b1;
          ex_mem_en  = 1'b1;
          if (load_use_hazard) begin
            // Branch operands are not ready yet, so a taken branch waits.
            id_ex_fl = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            if_id_fl = branch_taken;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Outputs are held inactive while reset is asserted.
  always_comb begin
    pc_enable     = reset & pc_en;
    if_id_enable  = reset & if_id_en;
    if_id_flush   = reset & if_id_fl;
    id_ex_enable  = reset & id_ex_en;
    id_ex_flush   = reset & id_ex_fl;
    ex_mem_enable = reset & ex_mem_en;
    mem_wb_flush  = reset & mem_wb_fl;
    halted        = (state_q == StHalt);
  end

`ifdef PIPE_STALL_PERF_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
    end else if ((state_q != StHalt) && !pc_enable) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Self-checking bench for pipeline_control_unit (MEM_TIMEOUT=4): vector table plus
// hand sequences for timeout, halt and asynchronous reset, checked through a scoreboard.
module tb_pipeline_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_use_hazard = 1'b0;
  logic        branch_taken = 1'b0;
  logic        dmem_req = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush;
  logic        ex_mem_enable, mem_wb_flush, halted;
  logic [31:0] stall_cycles;

  pipeline_control_unit #(
    .MEM_TIMEOUT(4),
    .CNT_W      (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .load_use_hazard(load_use_hazard),
    .branch_taken   (branch_taken),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .pc_enable      (pc_enable),
    .if_id_enable   (if_id_enable),
    .if_id_flush    (if_id_flush),
    .id_ex_enable   (id_ex_enable),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_enable  (ex_mem_enable),
    .mem_wb_flush   (mem_wb_flush),
    .halted         (halted),
    .stall_cycles   (stall_cycles)
  );

  always #5 clock = ~clock;

  // {pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, mem_wb_fl, halted}
  localparam logic [7:0] ONone = 8'b0000_0000;
  localparam logic [7:0] ONorm = 8'b1101_0100;
  localparam logic [7:0] OLu   = 8'b0001_1100;
  localparam logic [7:0] OBr   = 8'b1111_0100;
  localparam logic [7:0] OFrz  = 8'b0000_0010;
  localparam logic [7:0] OHlt  = 8'b0000_0001;

  // Input order: {load_use_hazard, branch_taken, dmem_req, dmem_ready}
  typedef struct {
    logic [3:0] in;
    logic [7:0] exp;
    string      nm;
  } vec_t;

  typedef struct {
    logic [7:0]  outs;
    logic [31:0] perf;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[14];
  int          total = 0;
  int          bad = 0;
  logic [31:0] perf_m = 32'd0;
  logic [7:0]  act;

  assign act = {pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
                ex_mem_enable, mem_wb_flush, halted};

  task automatic push_exp(input logic [7:0] outs, input string nm);
    exp_t e;
    e.outs = outs;
`ifdef PIPE_STALL_PERF_EN
    e.perf = perf_m;
`else
    e.perf = 32'd0;
`endif
    e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    e = sb.pop_front();
    total++;
    if (act !== e.outs) begin
      bad++;
      $display("FAIL %s outs: got %b required %b", e.nm, act, e.outs);
    end
    total++;
    if (stall_cycles !== e.perf) begin
      bad++;
      $display("FAIL %s stall_cycles: got %0d required %0d", e.nm, stall_cycles, e.perf);
    end
    // A stalled, non-halted cycle counts once the clock edge ends it.
    if (reset && !e.outs[7] && !e.outs[0]) perf_m = perf_m + 32'd1;
  endtask

  task automatic step(input logic [3:0] in, input logic [7:0] exp, input string nm);
    @(posedge clock);
    #1;
    {load_use_hazard, branch_taken, dmem_req, dmem_ready} = in;
    push_exp(exp, nm);
    @(negedge clock);
    check();
  endtask

  task automatic async_reset(input string nm);
    @(posedge clock);
    #2;
    reset = 1'b0;
    {load_use_hazard, branch_taken, dmem_req, dmem_ready} = 4'b0000;
    perf_m = 32'd0;
    #1;
    push_exp(ONone, nm);
    check();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{4'b0000, ONorm, "idle_after_reset"};
    vecs[1]  = '{4'b1100, OLu,   "load_use_over_branch"};
    vecs[2]  = '{4'b0000, ONorm, "after_load_use"};
    vecs[3]  = '{4'b0100, OBr,   "branch_taken"};
    vecs[4]  = '{4'b0000, ONorm, "after_branch"};
    vecs[5]  = '{4'b0010, OFrz,  "freeze_1"};
    vecs[6]  = '{4'b0010, OFrz,  "freeze_2"};
    vecs[7]  = '{4'b0010, OFrz,  "freeze_3"};
    vecs[8]  = '{4'b0011, ONorm, "ready_after_3_no_halt"};
    vecs[9]  = '{4'b0000, ONorm, "back_in_run"};
    vecs[10] = '{4'b1110, OFrz,  "freeze_beats_lu_br"};
    vecs[11] = '{4'b1011, OLu,   "ready_cycle_load_use"};
    vecs[12] = '{4'b0111, OBr,   "ready_cycle_branch"};
    vecs[13] = '{4'b1000, OLu,   "load_use_alone"};

    #2;
    push_exp(ONone, "in_reset");
    check();
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) step(vecs[i].in, vecs[i].exp, vecs[i].nm);

    // Reset mid-wait must clear the wait counter.
    step(4'b0010, OFrz, "pre_reset_freeze_1");
    step(4'b0010, OFrz, "pre_reset_freeze_2");
    async_reset("reset_mid_wait");
    step(4'b0010, OFrz, "post_reset_freeze_1");
    step(4'b0010, OFrz, "post_reset_freeze_2");
    step(4'b0010, OFrz, "post_reset_freeze_3");
    step(4'b0011, ONorm, "post_reset_ready");

    // Timeout: the 4th consecutive frozen cycle enters HALT.
    step(4'b0010, OFrz, "timeout_freeze_1");
    step(4'b0010, OFrz, "timeout_freeze_2");
    step(4'b0010, OFrz, "timeout_freeze_3");
    step(4'b0010, OFrz, "timeout_freeze_4");
    step(4'b0010, OHlt, "halted");
    step(4'b0011, OHlt, "halt_ignores_ready");
    step(4'b1100, OHlt, "halt_ignores_lu_br");
    step(4'b0000, OHlt, "halt_sticky");
    async_reset("reset_in_halt");
    step(4'b0000, ONorm, "run_after_halt_reset");
    step(4'b0100, OBr,   "branch_after_halt_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
